// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: datapath widths, register count and dump FSM types.
package mips32_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  // Register-dump controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  // One dump beat as presented to the consumer.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     data;
    logic                  last;
  } dump_beat_t;

endpackage : mips32_pkg

// File: rtl/mips32_reg_dump.sv
// Register-file dump engine: on a CPU halt edge or a manual start, walks
// registers FIRST_REG..LAST_REG and streams each one out as a valid/ready beat.
module mips32_reg_dump
  import mips32_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  halted,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  input  logic [WORD_W-1:0]     rf_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_addr,
  output logic [WORD_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

  dump_state_t           state;
  logic [REG_ADDR_W-1:0] index;
  logic                  prev_halted;
  logic                  armed;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  dump_beat_t            beat;
  logic                  trigger_c;

  // A halt edge only counts once the edge detector has seen one live sample
  // after reset, so a halted level already high out of reset cannot fire.
  assign trigger_c = start | (halted & ~prev_halted & armed);

  // Read address follows the walking index in every state.
  assign rf_rd_addr = index;

  assign out_valid = valid_q;
  assign out_addr  = beat.addr;
  assign out_data  = beat.data;
  assign out_last  = beat.last;
  assign busy      = busy_q;
  assign done      = done_q;

  // Dump FSM with registered outputs; synchronous active-low reset.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      index       <= FIRST_IDX;
      prev_halted <= 1'b0;
      armed       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      beat        <= '0;
    end else begin
      prev_halted <= halted;
      armed       <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (trigger_c) begin
            state  <= ST_READ;
            index  <= FIRST_IDX;
            busy_q <= 1'b1;
          end
        end
        ST_READ: begin
          beat.addr <= index;
          beat.data <= rf_rd_data;
          beat.last <= (index == LAST_IDX);
          valid_q   <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          // Beat stays frozen until the consumer takes it.
          if (out_ready) begin
            valid_q   <= 1'b0;
            beat.last <= 1'b0;
            if (beat.last) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              index <= index + REG_ADDR_W'(1);
              state <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          // Wait for both request sources to drop before re-arming.
          if (!halted && !start) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule : mips32_reg_dump

// File: tb/tb_mips32_reg_dump.sv
// Scoreboard bench for mips32_reg_dump: full-range instance and a 28..31 instance.
module tb_mips32_reg_dump;
  import mips32_pkg::*;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic rst_n, halted, start, out_ready;
  logic halted_b, start_b, out_ready_b;
  logic [31:0] rf [32];

  logic [4:0]  rf_rd_addr_a, out_addr_a, rf_rd_addr_b, out_addr_b;
  logic [31:0] rf_rd_data_a, out_data_a, rf_rd_data_b, out_data_b;
  logic        out_valid_a, out_last_a, busy_a, done_a;
  logic        out_valid_b, out_last_b, busy_b, done_b;

  assign rf_rd_data_a = rf[rf_rd_addr_a];
  assign rf_rd_data_b = rf[rf_rd_addr_b];

  mips32_reg_dump u_dut_a (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .start(start),
    .rf_rd_addr(rf_rd_addr_a), .rf_rd_data(rf_rd_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_addr(out_addr_a), .out_data(out_data_a), .out_last(out_last_a),
    .busy(busy_a), .done(done_a)
  );

  mips32_reg_dump #(.FIRST_REG(28), .LAST_REG(31)) u_dut_b (
    .clk1(clk1), .rst_n(rst_n), .halted(halted_b), .start(start_b),
    .rf_rd_addr(rf_rd_addr_b), .rf_rd_data(rf_rd_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_addr(out_addr_b), .out_data(out_data_b), .out_last(out_last_b),
    .busy(busy_b), .done(done_b)
  );

  int errors = 0;
  int checks = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic push_dump(input bit sel, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      exp_t e;
      e.addr = 5'(i);
      e.data = rf[i];
      e.last = (i == last);
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
    end
  endtask

  task automatic wait_done(input bit sel, input int max_cycles);
    bit seen = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      tick();
      if ((sel ? done_b : done_a) == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(sel ? "done_b_reached" : "done_a_reached", 64'(seen), 64'd1);
  endtask

  task automatic wait_beat_a(input logic [4:0] addr, input int max_cycles);
    bit seen = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      tick();
      if (out_valid_a && out_addr_a == addr) begin
        seen = 1'b1;
        break;
      end
    end
    check("beat_reached", 64'(seen), 64'd1);
  endtask

  task automatic pulse_start_a();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard monitor for instance A: compares accepted beats, checks hold stability.
  logic hold_a = 1'b0;
  exp_t held_a;
  exp_t ea;
  always @(negedge clk1) begin
    if (rst_n && hold_a) begin
      check("hold_valid_a", 64'(out_valid_a), 64'd1);
      check("hold_addr_a", 64'(out_addr_a), 64'(held_a.addr));
      check("hold_data_a", 64'(out_data_a), 64'(held_a.data));
      check("hold_last_a", 64'(out_last_a), 64'(held_a.last));
    end
    if (rst_n && out_valid_a && out_ready) begin
      check("beat_expected_a", 64'(qa.size() > 0), 64'd1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("beat_addr_a", 64'(out_addr_a), 64'(ea.addr));
        check("beat_data_a", 64'(out_data_a), 64'(ea.data));
        check("beat_last_a", 64'(out_last_a), 64'(ea.last));
      end
    end
    hold_a = rst_n && out_valid_a && !out_ready;
    held_a = '{addr: out_addr_a, data: out_data_a, last: out_last_a};
  end

  // Scoreboard monitor for instance B.
  exp_t eb;
  always @(negedge clk1) begin
    if (rst_n && out_valid_b && out_ready_b) begin
      check("beat_expected_b", 64'(qb.size() > 0), 64'd1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("beat_addr_b", 64'(out_addr_b), 64'(eb.addr));
        check("beat_data_b", 64'(out_data_b), 64'(eb.data));
        check("beat_last_b", 64'(out_last_b), 64'(eb.last));
      end
    end
  end

  initial begin
    rst_n = 1'b0; halted = 1'b0; start = 1'b0; out_ready = 1'b1;
    halted_b = 1'b0; start_b = 1'b0; out_ready_b = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;

    // Reset values
    repeat (3) tick();
    check("rst_valid", 64'(out_valid_a), 64'd0);
    check("rst_last", 64'(out_last_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_addr", 64'(out_addr_a), 64'd0);
    check("rst_data", 64'(out_data_a), 64'd0);
    check("rst_rdaddr_a", 64'(rf_rd_addr_a), 64'd0);
    check("rst_rdaddr_b", 64'(rf_rd_addr_b), 64'd28);
    rst_n = 1'b1;
    tick();

    // Full dump with R[i] = i via start pulse
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    push_dump(1'b0, 0, 31);
    pulse_start_a();
    check("t36_busy", 64'(busy_a), 64'd1);
    check("t36_valid_early", 64'(out_valid_a), 64'd0);
    tick();
    check("t36_first_valid", 64'(out_valid_a), 64'd1);
    check("t36_first_addr", 64'(out_addr_a), 64'd0);
    wait_done(1'b0, 200);
    check("t36_all_beats", 64'(qa.size()), 64'd0);
    check("t36_busy_done", 64'(busy_a), 64'd0);
    tick();
    check("t36_back_idle", 64'(done_a), 64'd0);

    // Program results: ADDI/ADD sequence then halt edge triggers dump
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd10; rf[2] = 32'd20; rf[3] = 32'd25; rf[4] = 32'd30; rf[5] = 32'd55;
    push_dump(1'b0, 0, 31);
    halted = 1'b1;
    tick();
    check("t37_busy", 64'(busy_a), 64'd1);
    tick();
    check("t37_first_valid", 64'(out_valid_a), 64'd1);
    wait_done(1'b0, 200);
    check("t37_all_beats", 64'(qa.size()), 64'd0);
    repeat (3) tick();
    check("t37_done_held", 64'(done_a), 64'd1);
    halted = 1'b0;
    tick();
    check("t37_back_idle", 64'(done_a), 64'd0);

    // Back-pressure on beat R3
    push_dump(1'b0, 0, 31);
    pulse_start_a();
    wait_beat_a(5'd3, 50);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t38_valid", 64'(out_valid_a), 64'd1);
      check("t38_addr", 64'(out_addr_a), 64'd3);
      check("t38_data", 64'(out_data_a), 64'd25);
    end
    out_ready = 1'b1;
    wait_done(1'b0, 200);
    check("t38_all_beats", 64'(qa.size()), 64'd0);
    tick();

    // Requests while busy and in DONE are ignored
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    push_dump(1'b0, 0, 31);
    pulse_start_a();
    repeat (5) tick();
    pulse_start_a();
    halted = 1'b1;
    repeat (7) tick();
    pulse_start_a();
    wait_done(1'b0, 200);
    check("t39_all_beats", 64'(qa.size()), 64'd0);
    pulse_start_a();
    check("t39_done_stay", 64'(done_a), 64'd1);
    repeat (3) tick();
    check("t39_done_halted", 64'(done_a), 64'd1);
    check("t39_not_busy", 64'(busy_a), 64'd0);
    halted = 1'b0;
    tick();
    check("t39_idle", 64'(done_a), 64'd0);
    repeat (10) tick();
    check("t39_no_redump", 64'(busy_a), 64'd0);

    // Reset mid-dump, halted high through reset, then restart
    for (int i = 0; i < 32; i++) rf[i] = 32'(i + 256);
    push_dump(1'b0, 0, 31);
    pulse_start_a();
    wait_beat_a(5'd7, 50);
    halted = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    check("t40_valid", 64'(out_valid_a), 64'd0);
    check("t40_busy", 64'(busy_a), 64'd0);
    check("t40_rdaddr", 64'(rf_rd_addr_a), 64'd0);
    qa.delete();
    rst_n = 1'b1;
    repeat (10) tick();
    check("t40_no_halt_dump", 64'(busy_a), 64'd0);
    push_dump(1'b0, 0, 31);
    pulse_start_a();
    check("t40_restart_busy", 64'(busy_a), 64'd1);
    tick();
    check("t40_restart_addr", 64'(out_addr_a), 64'd0);
    wait_done(1'b0, 200);
    check("t40_all_beats", 64'(qa.size()), 64'd0);
    halted = 1'b0;
    tick();

    // Partial range instance 28..31
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3 + 7);
    push_dump(1'b1, 28, 31);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("t41_busy", 64'(busy_b), 64'd1);
    check("t41_valid_early", 64'(out_valid_b), 64'd0);
    tick();
    check("t41_first_valid", 64'(out_valid_b), 64'd1);
    check("t41_first_addr", 64'(out_addr_b), 64'd28);
    wait_done(1'b1, 50);
    check("t41_all_beats", 64'(qb.size()), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mips32_reg_dump
